// File: rtl/load_store_unit.sv
// load_store_unit
//   Request-side front end for the byte-addressable `memory` block. Accepts one
//   byte/half/word load or store per handshake, issues word-aligned accesses to
//   memory and returns sign- or zero-extended load data. Sub-word stores are
//   done as read-modify-write because memory always writes a full word.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid_i       request present
//   req_ready_o       block is idle and can accept a request
//   req_we_i          1 = store, 0 = load
//   req_size_i        00 byte, 01 half, 10/11 word
//   req_unsigned_i    zero-extend load result
//   req_addr_i        byte address
//   req_wdata_i       right-justified store data
//   resp_valid_o      one-cycle completion pulse
//   resp_rdata_o      load result (0 for stores and errors)
//   misaligned_o      error flag, valid with resp_valid_o
//   mem_addr_o        word-aligned address to memory
//   mem_data_o        write data to memory
//   mem_read_en_o     read enable to memory
//   mem_write_en_o    write enable to memory
//   mem_data_i        combinational read data from memory
module load_store_unit #(
    parameter int unsigned       awidth    = 32,
    parameter int unsigned       dwidth    = 32,
    parameter logic [awidth-1:0] base_addr = 32'h01000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [awidth-1:0] req_addr_i,
    input  logic [dwidth-1:0] req_wdata_i,
    output logic              resp_valid_o,
    output logic [dwidth-1:0] resp_rdata_o,
    output logic              misaligned_o,
    output logic [awidth-1:0] mem_addr_o,
    output logic [dwidth-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [dwidth-1:0] mem_data_i
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;

    state_t            state, state_next;

    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        lane_q;
    logic [dwidth-1:0] wdata_q;
    logic              err_q;
    logic [dwidth-1:0] rdata_q;
    logic [awidth-1:0] mem_addr_q;
    logic [dwidth-1:0] mem_data_q;

    logic              accept;
    logic              req_misaligned;
    logic [4:0]        lane_shift;
    logic [dwidth-1:0] shifted;
    logic [dwidth-1:0] load_ext;
    logic [dwidth-1:0] lane_mask;
    logic [dwidth-1:0] merged;

    assign req_ready_o = (state == IDLE) && !rst;
    assign accept      = req_valid_i && req_ready_o;

    assign req_misaligned = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                            (req_size_i[1] && (req_addr_i[1:0] != 2'b00));

    // Byte lane of the latched address, expressed as a bit shift.
    assign lane_shift = {lane_q, 3'b000};
    assign shifted    = mem_data_i >> lane_shift;

    always_comb begin
        load_ext = shifted;
        case (size_q)
            2'b00:   load_ext = uns_q ? {{(dwidth-8){1'b0}}, shifted[7:0]}
                                      : {{(dwidth-8){shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = uns_q ? {{(dwidth-16){1'b0}}, shifted[15:0]}
                                      : {{(dwidth-16){shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Old word with the addressed lane(s) replaced by the store data.
    assign lane_mask = (size_q == 2'b00) ? {{(dwidth-8){1'b0}}, 8'hFF}
                                         : {{(dwidth-16){1'b0}}, 16'hFFFF};
    assign merged    = (mem_data_i & ~(lane_mask << lane_shift)) |
                       ((wdata_q & lane_mask) << lane_shift);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        resp_valid_o   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_misaligned)      state_next = RESP;
                    else if (!req_we_i)      state_next = LOAD;
                    else if (req_size_i[1])  state_next = WRITE;
                    else                     state_next = RMW_READ;
                end
            end
            LOAD: begin
                mem_read_en_o = !rst;
                state_next    = RESP;
            end
            RMW_READ: begin
                mem_read_en_o = !rst;
                state_next    = WRITE;
            end
            WRITE: begin
                // Gated by rst so an aborted store never commits.
                mem_write_en_o = !rst;
                state_next     = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            size_q     <= '0;
            uns_q      <= 1'b0;
            lane_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            mem_addr_q <= base_addr;
            mem_data_q <= '0;
        end else begin
            if (accept) begin
                size_q  <= req_size_i;
                uns_q   <= req_unsigned_i;
                lane_q  <= req_addr_i[1:0];
                wdata_q <= req_wdata_i;
                err_q   <= req_misaligned;
                rdata_q <= '0;
                // Memory-facing registers only move for requests that access memory.
                if (!req_misaligned) begin
                    mem_addr_q <= {req_addr_i[awidth-1:2], 2'b00};
                    if (req_we_i && req_size_i[1]) begin
                        mem_data_q <= req_wdata_i;
                    end
                end
            end
            if (state == LOAD) begin
                rdata_q <= load_ext;
            end
            if (state == RMW_READ) begin
                mem_data_q <= merged;
            end
        end
    end

    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign resp_rdata_o = rdata_q;
    assign misaligned_o = (state == RESP) && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit with a small word memory model attached.
//   Expected responses are queued when a request is driven and popped when
//   resp_valid_o is seen.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        misaligned_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_read_en_o;
    logic        mem_write_en_o;
    logic [31:0] mem_data_i;

    typedef struct packed {
        logic        mis;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          wr_cnt = 0;
    int          resp_cnt = 0;

    logic [31:0] mem [0:15];
    logic        obs_re   [1:8];
    logic        obs_we   [1:8];
    logic [31:0] obs_addr [1:8];
    logic [31:0] obs_wd   [1:8];

    load_store_unit #(
        .awidth   (32),
        .dwidth   (32),
        .base_addr(32'h01000000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_we_i      (req_we_i),
        .req_size_i    (req_size_i),
        .req_unsigned_i(req_unsigned_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .resp_valid_o  (resp_valid_o),
        .resp_rdata_o  (resp_rdata_o),
        .misaligned_o  (misaligned_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_read_en_o (mem_read_en_o),
        .mem_write_en_o(mem_write_en_o),
        .mem_data_i    (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data_i = mem[mem_addr_o[5:2]];

    always @(posedge clk) begin
        if (mem_write_en_o) mem[mem_addr_o[5:2]] <= mem_data_o;
    end

    always @(negedge clk) begin
        if (mem_write_en_o) wr_cnt++;
        if (resp_valid_o)   resp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_rdata"}, resp_rdata_o, e.rdata);
            check({tag, "_mis"}, 32'(misaligned_o), 32'(e.mis));
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
    endtask

    // Issues one request, records memory-side activity for 8 cycles after the
    // acceptance edge, and checks response latency and pulse count.
    task automatic issue(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_mis, input int exp_lat);
        int   k;
        int   lat;
        int   pulses;
        exp_t e;
        e.mis   = exp_mis;
        e.rdata = exp_rdata;
        sb.push_back(e);
        @(negedge clk);
        drive(we, size, uns, addr, wdata);
        req_valid_i = 1'b1;
        k = 0;
        while (!req_ready_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        lat    = 0;
        pulses = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            obs_re[c]   = mem_read_en_o;
            obs_we[c]   = mem_write_en_o;
            obs_addr[c] = mem_addr_o;
            obs_wd[c]   = mem_data_o;
            if (resp_valid_o) begin
                pulses++;
                if (lat == 0) begin
                    lat = c;
                    pop_compare(tag);
                end
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_pulses"}, 32'(pulses), 32'd1);
    endtask

    logic [31:0] b2b_addr [0:2];
    logic [31:0] b2b_wd   [0:2];
    logic        b2b_we   [0:2];
    logic [1:0]  b2b_size [0:2];
    logic        b2b_uns  [0:2];
    exp_t        b2b_exp  [0:2];
    int          acc_cyc  [0:3];
    int          rsp_cyc  [0:3];

    initial begin
        int   wr0;
        int   rc0;
        int   n_acc;
        int   n_resp;
        logic any_mem;

        rst         = 1'b1;
        req_valid_i = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h88776655;
        mem[1] = 32'h11223344;

        repeat (3) @(negedge clk);
        check("rst_ready_low", 32'(req_ready_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_mem_addr", mem_addr_o, 32'h01000000);
        check("rst_mem_data", mem_data_o, 32'h0);
        check("rst_rdata", resp_rdata_o, 32'h0);
        check("rst_outs", {28'h0, resp_valid_o, misaligned_o, mem_read_en_o, mem_write_en_o}, 32'h0);

        issue("ld_b_s", 1'b0, 2'b00, 1'b0, 32'h01000003, 32'h0, 32'hFFFFFF88, 1'b0, 2);
        check("ld_b_s_re", 32'(obs_re[1]), 32'd1);
        check("ld_b_s_addr", obs_addr[1], 32'h01000000);
        check("ld_b_s_re_once", 32'(obs_re[2]), 32'd0);
        issue("ld_b_u", 1'b0, 2'b00, 1'b1, 32'h01000003, 32'h0, 32'h00000088, 1'b0, 2);
        issue("ld_h_s", 1'b0, 2'b01, 1'b0, 32'h01000002, 32'h0, 32'hFFFF8877, 1'b0, 2);
        check("ld_h_s_addr", obs_addr[1], 32'h01000000);
        issue("ld_h_pos", 1'b0, 2'b01, 1'b0, 32'h01000000, 32'h0, 32'h00006655, 1'b0, 2);
        issue("ld_w", 1'b0, 2'b10, 1'b0, 32'h01000000, 32'h0, 32'h88776655, 1'b0, 2);
        check("ld_w_re", 32'(obs_re[1]), 32'd1);
        issue("ld_w_sz3", 1'b0, 2'b11, 1'b1, 32'h01000004, 32'h0, 32'h11223344, 1'b0, 2);

        wr0 = wr_cnt;
        issue("st_h_mis", 1'b1, 2'b01, 1'b0, 32'h01000003, 32'h00001234, 32'h0, 1'b1, 1);
        any_mem = 1'b0;
        for (int c = 1; c <= 8; c++) any_mem = any_mem | obs_re[c] | obs_we[c];
        check("st_h_mis_nomem", 32'(any_mem), 32'd0);
        check("st_h_mis_wrcnt", 32'(wr_cnt - wr0), 32'd0);
        check("st_h_mis_mem", mem[0], 32'h88776655);
        issue("ld_w_mis", 1'b0, 2'b10, 1'b0, 32'h01000002, 32'h0, 32'h0, 1'b1, 1);

        // Word store aborted by reset during its WRITE cycle.
        wr0 = wr_cnt;
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b0, 32'h01000000, 32'hDEADBEEF);
        req_valid_i = 1'b1;
        check("rstw_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        rst = 1'b1;
        rc0 = resp_cnt;
        #1;
        check("rstw_in_write", mem_data_o, 32'hDEADBEEF);
        check("rstw_we_gated", 32'(mem_write_en_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstw_mem", mem[0], 32'h88776655);
        check("rstw_ready", 32'(req_ready_o), 32'd1);
        check("rstw_mem_addr", mem_addr_o, 32'h01000000);
        check("rstw_mem_data", mem_data_o, 32'h0);
        check("rstw_rdata", resp_rdata_o, 32'h0);
        check("rstw_outs", {28'h0, resp_valid_o, misaligned_o, mem_read_en_o, mem_write_en_o}, 32'h0);
        repeat (4) @(negedge clk);
        check("rstw_no_resp", 32'(resp_cnt - rc0), 32'd0);
        check("rstw_wrcnt", 32'(wr_cnt - wr0), 32'd0);

        issue("st_b", 1'b1, 2'b00, 1'b0, 32'h01000001, 32'h000000AB, 32'h0, 1'b0, 3);
        check("st_b_rd", {30'h0, obs_re[1], obs_we[1]}, 32'h2);
        check("st_b_wr", {30'h0, obs_re[2], obs_we[2]}, 32'h1);
        check("st_b_wdata", obs_wd[2], 32'h8877AB55);
        check("st_b_waddr", obs_addr[2], 32'h01000000);
        check("st_b_mem", mem[0], 32'h8877AB55);
        issue("ld_w_after", 1'b0, 2'b10, 1'b0, 32'h01000000, 32'h0, 32'h8877AB55, 1'b0, 2);

        // Back-to-back requests with req_valid_i held high.
        b2b_we[0] = 1'b0; b2b_size[0] = 2'b10; b2b_uns[0] = 1'b0;
        b2b_addr[0] = 32'h01000004; b2b_wd[0] = 32'h0;
        b2b_exp[0].mis = 1'b0; b2b_exp[0].rdata = 32'h11223344;
        b2b_we[1] = 1'b0; b2b_size[1] = 2'b01; b2b_uns[1] = 1'b1;
        b2b_addr[1] = 32'h01000006; b2b_wd[1] = 32'h0;
        b2b_exp[1].mis = 1'b0; b2b_exp[1].rdata = 32'h00001122;
        b2b_we[2] = 1'b1; b2b_size[2] = 2'b00; b2b_uns[2] = 1'b0;
        b2b_addr[2] = 32'h01000004; b2b_wd[2] = 32'h000000CD;
        b2b_exp[2].mis = 1'b0; b2b_exp[2].rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            acc_cyc[i] = -1;
            rsp_cyc[i] = -1;
        end
        n_acc  = 0;
        n_resp = 0;
        @(negedge clk);
        drive(b2b_we[0], b2b_size[0], b2b_uns[0], b2b_addr[0], b2b_wd[0]);
        req_valid_i = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (resp_valid_o) begin
                if (n_resp < 4) rsp_cyc[n_resp] = cyc;
                n_resp++;
                pop_compare("b2b");
            end
            if (req_ready_o && req_valid_i) begin
                if (n_acc < 4) acc_cyc[n_acc] = cyc;
                if (n_acc < 3) sb.push_back(b2b_exp[n_acc]);
                n_acc++;
                @(posedge clk);
                #1;
                if (n_acc < 3) drive(b2b_we[n_acc], b2b_size[n_acc], b2b_uns[n_acc],
                                     b2b_addr[n_acc], b2b_wd[n_acc]);
                else req_valid_i = 1'b0;
            end
            @(negedge clk);
        end
        req_valid_i = 1'b0;
        check("b2b_n_acc", 32'(n_acc), 32'd3);
        check("b2b_n_resp", 32'(n_resp), 32'd3);
        check("b2b_acc0", 32'(acc_cyc[0]), 32'd0);
        check("b2b_acc1", 32'(acc_cyc[1]), 32'd3);
        check("b2b_acc2", 32'(acc_cyc[2]), 32'd6);
        check("b2b_rsp0", 32'(rsp_cyc[0]), 32'd2);
        check("b2b_rsp1", 32'(rsp_cyc[1]), 32'd5);
        check("b2b_rsp2", 32'(rsp_cyc[2]), 32'd9);
        check("b2b_mem", mem[1], 32'h112233CD);
        issue("ld_w_b2b", 1'b0, 2'b10, 1'b0, 32'h01000004, 32'h0, 32'h112233CD, 1'b0, 2);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
